// File: rtl/bus_slot_scheduler_pkg.sv
// Shared types and constants for the SRAM bus slot scheduler.
// Slot numbering fixes the order of owners inside one character time.
package bus_slot_scheduler_pkg;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int VADDR_W = 12;
  localparam int SLOT_W  = 2;

  localparam logic [ADDR_W-1:0] VRAM_BASE_DEF = 17'h08000;
  localparam logic [ADDR_W-1:0] CROM_BASE_DEF = 17'h18000;

  typedef enum logic [SLOT_W-1:0] {
    SLOT_VRAM = 2'd0,
    SLOT_CROM = 2'd1,
    SLOT_CPU  = 2'd2,
    SLOT_SPI  = 2'd3
  } slot_e;

  // Video address bit 11 only selects VRAM vs char-ROM; the low 11 bits offset the base.
  function automatic logic [ADDR_W-1:0] video_map(input logic [ADDR_W-1:0] base,
                                                  input logic [VADDR_W-1:0] va);
    return base + {{(ADDR_W-11){1'b0}}, va[10:0]};
  endfunction

endpackage

// File: rtl/bus_slot_scheduler_if.sv
// Bundle of video, CPU, SPI and SRAM-pin signals around the slot scheduler.
// slave = scheduler side, master = everything connected to it.
interface bus_slot_scheduler_if;

  logic [bus_slot_scheduler_pkg::VADDR_W-1:0] video_addr;
  logic                                       video_ram_strobe;
  logic                                       video_rom_strobe;
  logic [bus_slot_scheduler_pkg::DATA_W-1:0]  video_data;
  logic [bus_slot_scheduler_pkg::ADDR_W-1:0]  cpu_addr;
  logic                                       cpu_we;
  logic [bus_slot_scheduler_pkg::DATA_W-1:0]  cpu_din;
  logic [bus_slot_scheduler_pkg::DATA_W-1:0]  cpu_dout;
  logic                                       cpu_en;
  logic                                       spi_req;
  logic                                       spi_we;
  logic [bus_slot_scheduler_pkg::ADDR_W-1:0]  spi_addr;
  logic [bus_slot_scheduler_pkg::DATA_W-1:0]  spi_din;
  logic [bus_slot_scheduler_pkg::DATA_W-1:0]  spi_dout;
  logic                                       spi_ack;
  logic [bus_slot_scheduler_pkg::ADDR_W-1:0]  ram_addr;
  logic                                       ram_oe_n;
  logic                                       ram_we_n;
  logic [bus_slot_scheduler_pkg::DATA_W-1:0]  ram_dq_out;
  logic                                       ram_dq_oe;
  logic [bus_slot_scheduler_pkg::DATA_W-1:0]  ram_dq_in;

  modport slave (
    input  video_addr, cpu_addr, cpu_we, cpu_din, spi_req, spi_we, spi_addr, spi_din, ram_dq_in,
    output video_ram_strobe, video_rom_strobe, video_data, cpu_dout, cpu_en,
           spi_dout, spi_ack, ram_addr, ram_oe_n, ram_we_n, ram_dq_out, ram_dq_oe
  );

  modport master (
    output video_addr, cpu_addr, cpu_we, cpu_din, spi_req, spi_we, spi_addr, spi_din, ram_dq_in,
    input  video_ram_strobe, video_rom_strobe, video_data, cpu_dout, cpu_en,
           spi_dout, spi_ack, ram_addr, ram_oe_n, ram_we_n, ram_dq_out, ram_dq_oe
  );

endinterface

// File: rtl/bus_slot_scheduler_slot_timer.sv
// Free-running phase/slot counter: PHASES cycles per slot, four slots per character time.
module bus_slot_scheduler_slot_timer
  import bus_slot_scheduler_pkg::*;
#(
  parameter int PHASES = 4,
  localparam int PW = $clog2(PHASES)
) (
  input  logic          clk,
  input  logic          reset,
  output slot_e         slot_o,
  output logic [PW-1:0] phase_o,
  output logic          first_o,
  output logic          last_o
);

  slot_e         slot_q, slot_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          last;

  assign last = (phase_q == PW'(PHASES - 1));

  always_comb begin
    slot_d  = slot_q;
    phase_d = phase_q + PW'(1);
    if (last) begin
      phase_d = '0;
      slot_d  = slot_e'(slot_q + 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q  <= SLOT_VRAM;
      phase_q <= '0;
    end else begin
      slot_q  <= slot_d;
      phase_q <= phase_d;
    end
  end

  assign slot_o  = slot_q;
  assign phase_o = phase_q;
  assign first_o = (phase_q == '0);
  assign last_o  = last;

endmodule

// File: rtl/bus_slot_scheduler.sv
// Time-division owner of the shared SRAM bus: VRAM, char-ROM, CPU and SPI slots.
// All bus outputs are a registered decode of the timer, so pins trail the counter by one cycle.
module bus_slot_scheduler
  import bus_slot_scheduler_pkg::*;
#(
  parameter int                PHASES    = 4,
  parameter logic [ADDR_W-1:0] VRAM_BASE = VRAM_BASE_DEF,
  parameter logic [ADDR_W-1:0] CROM_BASE = CROM_BASE_DEF,
  localparam int               PW        = $clog2(PHASES)
) (
  input  logic                clk,
  input  logic                reset,
  bus_slot_scheduler_if.slave bus
);

  slot_e         slot;
  logic [PW-1:0] phase;
  logic          first, last, mid, early, is_cpu, acc, req_rise;

  logic              ram_strobe_q, ram_strobe_d, rom_strobe_q, rom_strobe_d;
  logic              oe_n_q, oe_n_d, we_n_q, we_n_d, dq_oe_q, dq_oe_d;
  logic              cpu_en_q, cpu_en_d, spi_ack_q, spi_ack_d;
  logic              acc_we_q, acc_we_d, spi_active_q, spi_active_d;
  logic              pend_q, pend_d, spi_req_q;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d, cpu_dout_q, cpu_dout_d, spi_dout_q, spi_dout_d;

  bus_slot_scheduler_slot_timer #(.PHASES(PHASES)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .slot_o  (slot),
    .phase_o (phase),
    .first_o (first),
    .last_o  (last)
  );

  assign mid      = !first && !last;
  assign early    = (phase <= PW'(PHASES - 2));
  assign is_cpu   = (slot == SLOT_CPU);
  assign req_rise = bus.spi_req & ~spi_req_q;

  always_comb begin
    ram_strobe_d = 1'b0;
    rom_strobe_d = 1'b0;
    oe_n_d       = 1'b1;
    we_n_d       = 1'b1;
    dq_oe_d      = 1'b0;
    cpu_en_d     = 1'b0;
    spi_ack_d    = 1'b0;
    ram_addr_d   = ram_addr_q;
    dq_out_d     = dq_out_q;
    cpu_dout_d   = cpu_dout_q;
    spi_dout_d   = spi_dout_q;
    acc_we_d     = acc_we_q;
    spi_active_d = spi_active_q;
    pend_d       = pend_q;

    // The SPI slot commits at its first phase; later requests wait a full character time.
    if (slot == SLOT_SPI && first) spi_active_d = pend_q;
    acc = is_cpu || (slot == SLOT_SPI && spi_active_d);

    case (slot)
      SLOT_VRAM, SLOT_CROM: begin
        ram_strobe_d = (slot == SLOT_VRAM) && early;
        rom_strobe_d = (slot == SLOT_CROM) && early;
        oe_n_d       = first;
        if (phase == PW'(1))
          ram_addr_d = video_map((slot == SLOT_VRAM) ? VRAM_BASE : CROM_BASE, bus.video_addr);
      end
      SLOT_CPU, SLOT_SPI: begin
        if (acc) begin
          if (first) begin
            acc_we_d = is_cpu ? bus.cpu_we  : bus.spi_we;
            dq_out_d = is_cpu ? bus.cpu_din : bus.spi_din;
          end
          if (phase == PW'(1)) ram_addr_d = is_cpu ? bus.cpu_addr : bus.spi_addr;
          if (acc_we_d) begin
            dq_oe_d = 1'b1;
            we_n_d  = !mid;
          end else begin
            oe_n_d = first;
            if (last) begin
              if (is_cpu) cpu_dout_d = bus.ram_dq_in;
              else        spi_dout_d = bus.ram_dq_in;
            end
          end
          if (last) begin
            if (is_cpu) begin
              cpu_en_d = 1'b1;
            end else begin
              spi_ack_d    = 1'b1;
              pend_d       = 1'b0;
              spi_active_d = 1'b0;
            end
          end
        end
      end
      default: ;
    endcase

    if (req_rise) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_strobe_q <= 1'b0;
      rom_strobe_q <= 1'b0;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      cpu_en_q     <= 1'b0;
      spi_ack_q    <= 1'b0;
      ram_addr_q   <= '0;
      dq_out_q     <= '0;
      cpu_dout_q   <= '0;
      spi_dout_q   <= '0;
      acc_we_q     <= 1'b0;
      spi_active_q <= 1'b0;
      pend_q       <= 1'b0;
      spi_req_q    <= 1'b0;
    end else begin
      ram_strobe_q <= ram_strobe_d;
      rom_strobe_q <= rom_strobe_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      dq_oe_q      <= dq_oe_d;
      cpu_en_q     <= cpu_en_d;
      spi_ack_q    <= spi_ack_d;
      ram_addr_q   <= ram_addr_d;
      dq_out_q     <= dq_out_d;
      cpu_dout_q   <= cpu_dout_d;
      spi_dout_q   <= spi_dout_d;
      acc_we_q     <= acc_we_d;
      spi_active_q <= spi_active_d;
      pend_q       <= pend_d;
      spi_req_q    <= bus.spi_req;
    end
  end

  assign bus.video_ram_strobe = ram_strobe_q;
  assign bus.video_rom_strobe = rom_strobe_q;
  assign bus.video_data       = bus.ram_dq_in;
  assign bus.cpu_dout         = cpu_dout_q;
  assign bus.cpu_en           = cpu_en_q;
  assign bus.spi_dout         = spi_dout_q;
  assign bus.spi_ack          = spi_ack_q;
  assign bus.ram_addr         = ram_addr_q;
  assign bus.ram_oe_n         = oe_n_q;
  assign bus.ram_we_n         = we_n_q;
  assign bus.ram_dq_out       = dq_out_q;
  assign bus.ram_dq_oe        = dq_oe_q;

endmodule

// File: tb/tb_bus_slot_scheduler.sv
// Directed bench for bus_slot_scheduler at PHASES=4; cycle N = Nth cycle after reset release,
// so slot = (N/4)%4 and phase = N%4.
module tb_bus_slot_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = -1;

  always #5 clk = ~clk;

  bus_slot_scheduler_if bus_if ();

  bus_slot_scheduler #(.PHASES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    cyc++;
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int ack_cyc, last_en, en_cnt, exp_en, ovl, oewe, per_err, slot_err;

    bus_if.video_addr = 12'h005;
    bus_if.cpu_addr   = 17'h00200;
    bus_if.cpu_we     = 1'b0;
    bus_if.cpu_din    = 8'h00;
    bus_if.spi_req    = 1'b0;
    bus_if.spi_we     = 1'b0;
    bus_if.spi_addr   = 17'h00000;
    bus_if.spi_din    = 8'h00;
    bus_if.ram_dq_in  = 8'h41;

    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("txn reset hold 5 cycles");
    check_eq("rst_ram_strobe", 32'(bus_if.video_ram_strobe), 32'd0);
    check_eq("rst_rom_strobe", 32'(bus_if.video_rom_strobe), 32'd0);
    check_eq("rst_cpu_en",     32'(bus_if.cpu_en),           32'd0);
    check_eq("rst_spi_ack",    32'(bus_if.spi_ack),          32'd0);
    check_eq("rst_oe_n",       32'(bus_if.ram_oe_n),         32'd1);
    check_eq("rst_we_n",       32'(bus_if.ram_we_n),         32'd1);
    check_eq("rst_dq_oe",      32'(bus_if.ram_dq_oe),        32'd0);
    check_eq("rst_ram_addr",   32'(bus_if.ram_addr),         32'h0);
    check_eq("rst_cpu_dout",   32'(bus_if.cpu_dout),         32'h0);
    check_eq("rst_spi_dout",   32'(bus_if.spi_dout),         32'h0);
    reset = 1'b0;
    cyc = -1;

    // Slot 0 VRAM and slot 1 char-ROM
    $display("txn video fetch vram 005 then crom 8A3");
    to_cyc(0);
    check_eq("c0_ram_strobe", 32'(bus_if.video_ram_strobe), 32'd1);
    check_eq("c0_oe_n",       32'(bus_if.ram_oe_n),         32'd1);
    to_cyc(1);
    check_eq("c1_ram_addr",   32'(bus_if.ram_addr),         32'h08005);
    check_eq("c1_oe_n",       32'(bus_if.ram_oe_n),         32'd0);
    to_cyc(3);
    check_eq("c3_ram_strobe", 32'(bus_if.video_ram_strobe), 32'd0);
    check_eq("c3_oe_n",       32'(bus_if.ram_oe_n),         32'd0);
    check_eq("c3_ram_addr",   32'(bus_if.ram_addr),         32'h08005);
    check_eq("c3_video_data", 32'(bus_if.video_data),       32'h41);
    bus_if.video_addr = 12'h8A3;
    to_cyc(4);
    check_eq("c4_rom_strobe", 32'(bus_if.video_rom_strobe), 32'd1);
    check_eq("c4_ram_strobe", 32'(bus_if.video_ram_strobe), 32'd0);
    to_cyc(5);
    check_eq("c5_ram_addr",   32'(bus_if.ram_addr),         32'h180A3);
    to_cyc(6);
    bus_if.cpu_we  = 1'b1;
    bus_if.cpu_din = 8'h5A;

    // Slot 2 CPU write of 5A to 00200
    $display("txn cpu write 00200 <= 5A");
    to_cyc(8);
    check_eq("c8_dq_oe",      32'(bus_if.ram_dq_oe),  32'd1);
    check_eq("c8_we_n",       32'(bus_if.ram_we_n),   32'd1);
    check_eq("c8_dq_out",     32'(bus_if.ram_dq_out), 32'h5A);
    check_eq("c8_cpu_en",     32'(bus_if.cpu_en),     32'd0);
    to_cyc(9);
    check_eq("c9_we_n",       32'(bus_if.ram_we_n),   32'd0);
    check_eq("c9_ram_addr",   32'(bus_if.ram_addr),   32'h00200);
    to_cyc(10);
    check_eq("c10_we_n",      32'(bus_if.ram_we_n),   32'd0);
    check_eq("c10_oe_n",      32'(bus_if.ram_oe_n),   32'd1);
    check_eq("c10_cpu_en",    32'(bus_if.cpu_en),     32'd0);
    to_cyc(11);
    check_eq("c11_we_n",      32'(bus_if.ram_we_n),   32'd1);
    check_eq("c11_dq_oe",     32'(bus_if.ram_dq_oe),  32'd1);
    check_eq("c11_cpu_en",    32'(bus_if.cpu_en),     32'd1);
    to_cyc(13);
    check_eq("c13_dq_oe",     32'(bus_if.ram_dq_oe),  32'd0);
    check_eq("c13_cpu_en",    32'(bus_if.cpu_en),     32'd0);
    check_eq("c13_addr_hold", 32'(bus_if.ram_addr),   32'h00200);
    to_cyc(14);
    bus_if.cpu_we    = 1'b0;
    bus_if.ram_dq_in = 8'h5A;

    // Next character time: CPU read back
    $display("txn cpu read 00200 expect 5A");
    to_cyc(25);
    check_eq("c25_oe_n",      32'(bus_if.ram_oe_n),   32'd0);
    to_cyc(26);
    check_eq("c26_cpu_dout",  32'(bus_if.cpu_dout),   32'h00);
    to_cyc(27);
    check_eq("c27_cpu_en",    32'(bus_if.cpu_en),     32'd1);
    check_eq("c27_cpu_dout",  32'(bus_if.cpu_dout),   32'h5A);

    // SPI request arriving at slot 3 phase 2 waits for the next slot 3
    $display("txn spi read 1FFFF expect C3");
    to_cyc(30);
    bus_if.spi_req   = 1'b1;
    bus_if.spi_we    = 1'b0;
    bus_if.spi_addr  = 17'h1FFFF;
    bus_if.ram_dq_in = 8'hC3;
    ack_cyc = -1;
    for (int k = 0; k < 40 && ack_cyc < 0; k++) begin
      next_cyc();
      if (cyc == 45) begin
        check_eq("c45_ram_addr", 32'(bus_if.ram_addr), 32'h1FFFF);
        check_eq("c45_oe_n",     32'(bus_if.ram_oe_n), 32'd0);
      end
      if (bus_if.spi_ack) ack_cyc = cyc;
    end
    check_eq("spi_ack_cycle", 32'(ack_cyc), 32'd47);
    check_eq("spi_dout",      32'(bus_if.spi_dout), 32'hC3);
    bus_if.spi_req = 1'b0;
    next_cyc();
    check_eq("spi_ack_pulse", 32'(bus_if.spi_ack), 32'd0);

    // Free run with random CPU/SPI traffic; count rule violations
    $display("txn free run 1000 cycles");
    last_en = -1; en_cnt = 0; exp_en = 0; ovl = 0; oewe = 0; per_err = 0; slot_err = 0;
    for (int k = 0; k < 1000; k++) begin
      bus_if.cpu_we   = 1'($urandom_range(0, 1));
      bus_if.cpu_din  = 8'($urandom);
      bus_if.cpu_addr = 17'($urandom);
      bus_if.spi_we   = 1'($urandom_range(0, 1));
      bus_if.spi_addr = 17'($urandom);
      bus_if.spi_din  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus_if.spi_req = ~bus_if.spi_req;
      next_cyc();
      if (bus_if.video_ram_strobe && bus_if.video_rom_strobe) ovl++;
      if (!bus_if.ram_oe_n && !bus_if.ram_we_n) oewe++;
      if (bus_if.video_ram_strobe && (cyc % 16) >= 4) slot_err++;
      if (bus_if.video_rom_strobe && ((cyc % 16) < 4 || (cyc % 16) >= 8)) slot_err++;
      if ((cyc % 16) == 11) exp_en++;
      if (bus_if.cpu_en) begin
        en_cnt++;
        if (last_en >= 0 && cyc - last_en != 16) per_err++;
        last_en = cyc;
      end
    end
    check_eq("run_strobe_overlap", 32'(ovl),      32'd0);
    check_eq("run_oe_we_both_low", 32'(oewe),     32'd0);
    check_eq("run_strobe_slot",    32'(slot_err), 32'd0);
    check_eq("run_cpu_en_period",  32'(per_err),  32'd0);
    check_eq("run_cpu_en_count",   32'(en_cnt),   32'(exp_en));

    // Reset mid CPU write aborts the access
    $display("txn reset during cpu write at slot 2 phase 2");
    reset = 1'b1;
    bus_if.spi_req = 1'b0;
    repeat (3) next_cyc();
    reset = 1'b0;
    cyc = -1;
    bus_if.cpu_we   = 1'b1;
    bus_if.cpu_din  = 8'hA5;
    bus_if.cpu_addr = 17'h00300;
    to_cyc(10);
    check_eq("r10_we_n",  32'(bus_if.ram_we_n),  32'd0);
    check_eq("r10_dq_oe", 32'(bus_if.ram_dq_oe), 32'd1);
    reset = 1'b1;
    en_cnt = 0;
    next_cyc();
    check_eq("rst_mid_we_n",  32'(bus_if.ram_we_n),  32'd1);
    check_eq("rst_mid_dq_oe", 32'(bus_if.ram_dq_oe), 32'd0);
    if (bus_if.cpu_en) en_cnt++;
    for (int k = 0; k < 3; k++) begin
      next_cyc();
      if (bus_if.cpu_en) en_cnt++;
    end
    reset = 1'b0;
    cyc = -1;
    for (int k = 0; k < 11; k++) begin
      next_cyc();
      if (bus_if.cpu_en) en_cnt++;
    end
    check_eq("rst_no_cpu_en", 32'(en_cnt), 32'd0);
    next_cyc();
    check_eq("rst_cpu_en_c11", 32'(bus_if.cpu_en), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
